// File: rtl/twiddle_requant_4_2.sv
// Requantiser after the CSD twiddle multiplier. It removes the coefficient scaling with
// round-half-up, saturates to NBITS, tracks the frame position and counts saturations.
module twiddle_requant_4_2 #(
   parameter int NBITS      = 12,
   parameter int NBITScoeff = 11,
   parameter int NBITS_in   = NBITS + NBITScoeff + 1,
   parameter int FRAME      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [2*NBITS_in-1:0] muestra_in,
   input  logic                  clr_stats,
   output logic                  out_valid,
   output logic [2*NBITS-1:0]    muestra_out,
   output logic                  frame_start,
   output logic [2:0]            sample_idx,
   output logic                  sat_flag,
   output logic [7:0]            sat_count
);

   localparam int SH = NBITScoeff - 2;
   localparam int SW = NBITS_in + 1;
   localparam int RW = NBITS_in + 1 - SH;

   localparam logic signed [SW-1:0]  Half   = SW'(2 ** (SH - 1));
   localparam logic signed [RW-1:0]  MaxVal = RW'(2 ** (NBITS - 1) - 1);
   localparam logic signed [RW-1:0]  MinVal = -(RW'(2 ** (NBITS - 1)));
   localparam logic [NBITS-1:0]      OutMax = {1'b0, {(NBITS - 1){1'b1}}};
   localparam logic [NBITS-1:0]      OutMin = {1'b1, {(NBITS - 1){1'b0}}};
   localparam logic [2:0]            LastIdx = 3'(FRAME - 1);

   // Frame position of the next accepted input sample
   logic [2:0] cnt_q, cnt_d;

   // Stage 1 state
   logic                 s1_valid_q;
   logic signed [RW-1:0] r_re_q, r_im_q, r_re_d, r_im_d;
   logic [2:0]           s1_idx_q;

   // Stage 2 (output) state
   logic               out_valid_q;
   logic [2*NBITS-1:0] out_q;
   logic               fs_q;
   logic [2:0]         idx_q;
   logic               out_sat_q;

   logic       flag_q;
   logic [7:0] count_q;

   logic signed [SW-1:0] sum_re, sum_im;
   logic [NBITS-1:0]     sat_re, sat_im;
   logic                 clip_re, clip_im;
   logic                 unused_lsb;

   // One guard bit keeps full-scale + half from overflowing before the shift
   always_comb begin
      sum_re = $signed({muestra_in[2*NBITS_in-1], muestra_in[2*NBITS_in-1:NBITS_in]}) + Half;
      sum_im = $signed({muestra_in[NBITS_in-1], muestra_in[NBITS_in-1:0]}) + Half;
      r_re_d = sum_re[SW-1:SH];
      r_im_d = sum_im[SW-1:SH];
   end

   assign unused_lsb = ^{sum_re[SH-1:0], sum_im[SH-1:0]};

   always_comb begin
      cnt_d = cnt_q;
      if (in_valid) begin
         cnt_d = (cnt_q == LastIdx) ? 3'd0 : cnt_q + 3'd1;
      end
   end

   always_comb begin
      clip_re = 1'b0;
      sat_re  = r_re_q[NBITS-1:0];
      if (r_re_q > MaxVal) begin
         clip_re = 1'b1;
         sat_re  = OutMax;
      end else if (r_re_q < MinVal) begin
         clip_re = 1'b1;
         sat_re  = OutMin;
      end
   end

   always_comb begin
      clip_im = 1'b0;
      sat_im  = r_im_q[NBITS-1:0];
      if (r_im_q > MaxVal) begin
         clip_im = 1'b1;
         sat_im  = OutMax;
      end else if (r_im_q < MinVal) begin
         clip_im = 1'b1;
         sat_im  = OutMin;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= 3'd0;
         s1_valid_q <= 1'b0;
         r_re_q     <= '0;
         r_im_q     <= '0;
         s1_idx_q   <= 3'd0;
      end else begin
         cnt_q      <= cnt_d;
         s1_valid_q <= in_valid;
         if (in_valid) begin
            r_re_q   <= r_re_d;
            r_im_q   <= r_im_d;
            s1_idx_q <= cnt_q;
         end
      end
   end

   // Data and index hold across bubbles; only frame_start drops
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
         fs_q        <= 1'b0;
         idx_q       <= 3'd0;
         out_sat_q   <= 1'b0;
      end else begin
         out_valid_q <= s1_valid_q;
         fs_q        <= 1'b0;
         if (s1_valid_q) begin
            out_q     <= {sat_re, sat_im};
            fs_q      <= (s1_idx_q == 3'd0);
            idx_q     <= s1_idx_q;
            out_sat_q <= clip_re | clip_im;
         end
      end
   end

   // Statistics follow the visible output; a coincident clear wins
   always_ff @(posedge clk) begin
      if (rst || clr_stats) begin
         flag_q  <= 1'b0;
         count_q <= 8'd0;
      end else if (out_valid_q && out_sat_q) begin
         flag_q <= 1'b1;
         if (count_q != 8'hff) begin
            count_q <= count_q + 8'd1;
         end
      end
   end

   assign out_valid   = out_valid_q;
   assign muestra_out = out_q;
   assign frame_start = fs_q;
   assign sample_idx  = idx_q;
   assign sat_flag    = flag_q;
   assign sat_count   = count_q;

endmodule

// File: doc/twiddle_requant_4_2.md
Name: twiddle_requant_4_2

Overview:
- Receive-side companion to the CSD twiddle multiplier stage of the 4-parallel FFT datapath.
- Accepts full-precision complex products of width NBITS_in per part. These are either multiplied samples or pass-through samples pre-scaled by 2^(NBITScoeff-2).
- Removes the coefficient scaling with round-half-up, saturates back to NBITS, and re-registers the stream.
- Tracks the 8-sample twiddle frame position and reports saturation statistics so the next butterfly stage receives aligned, NBITS-wide samples.

Parameters:
- NBITS, 12, output sample width per real/imag part.
- NBITScoeff, 11, coefficient width; scaling shift SH = NBITScoeff-2 (9 by default).
- NBITS_in, NBITS+NBITScoeff+1, input width per real/imag part (24 by default).
- FRAME, 8, samples per twiddle frame (same period as the multiplier's cycle counter).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  muestra_in carries a valid sample this cycle.
- muestra_in  input  2*NBITS_in  {real, imag}; real in upper half; signed two's complement.
- clr_stats  input  1  synchronous clear of sat_flag and sat_count.
- out_valid  output  1  muestra_out is valid.
- muestra_out  output  2*NBITS  {real, imag}; real in upper half; signed.
- frame_start  output  1  high with out_valid on the output sample at frame index 0.
- sample_idx  output  3  frame index of the current output sample (0..FRAME-1).
- sat_flag  output  1  sticky; set when any part of any valid sample saturated.
- sat_count  output  8  count of saturated valid samples; saturates at 255.

Behaviour:
- Reset (rst=1 at a clock edge): out_valid=0, muestra_out=0, frame_start=0, sample_idx=0, sat_flag=0, sat_count=0, internal frame counter=0, all pipeline valid bits cleared.
  - Reset mid-stream drops in-flight samples. The first in_valid after reset is frame index 0.
- Pipeline: 2 stages, fixed latency of 2 clocks from an in_valid edge to the out_valid edge.
  - No backpressure; bubbles (in_valid=0) propagate unchanged as out_valid=0.
- Stage 1 (registered), per part x:
  - r = (sign-extend x to NBITS_in+1) + 2^(SH-1), arithmetic shift right by SH.
  - Result width NBITS_in+1-SH (16 by default).
  - Rounding is half-up toward +inf: 5.5 -> 6, -5.5 -> -5.
  - The frame index is captured alongside the sample.
- Stage 2 (registered):
  - If r > 2^(NBITS-1)-1, output 2047; if r < -2^(NBITS-1), output -2048; otherwise output r[NBITS-1:0].
  - Real and imag are saturated independently. A sample counts as saturated if either part clipped.
- Frame counter: increments on each accepted in_valid, wraps FRAME-1 -> 0; holds during bubbles.
  - sample_idx and frame_start are delayed to match the data.
- When out_valid=0: muestra_out, sample_idx and frame_start hold their last values, except frame_start, which is forced to 0.
- Statistics:
  - On a saturated valid output, sat_flag<=1 and sat_count<=min(sat_count+1,255).
  - clr_stats in the same cycle as a saturating output: clear wins (result 0/0).
  - rst overrides clr_stats.
- Width rule: the stage-1 sum uses one guard bit, so a full-scale input (2^(NBITS_in-1)-1) plus the rounding constant must not overflow.

Test Plan:
- Pass-through: real=5*512=2560, imag=-3*512=-1536, single in_valid -> two clocks later out_valid=1, out {5,-3}, sat_flag=0.
- Rounding: real=2816 (5.5), imag=-2816 (-5.5) -> out {6,-5}; real=2815 -> 5; imag=-2817 -> -6.
- Saturation: real=2048*512, imag=-2049*512 -> out {2047,-2048}, sat_flag=1, sat_count=1; 300 more saturating samples -> sat_count=255.
- Frame alignment: 10 valid samples with bubbles after samples 3 and 7 -> sample_idx sequence 0..7,0,1; frame_start high on 1st and 9th outputs only; out_valid gaps match the bubbles.
- Reset mid-stream: assert rst one cycle after in_valid samples 4 and 5 -> no out_valid for them, stats 0; next input emerges with sample_idx=0, frame_start=1.
- clr_stats coincident with a saturating output -> sat_flag=0, sat_count=0 on the next cycle.
